// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch stage with IF/ID register. Fetches from a
//            wait-stated memory using a req/ready handshake and holds one
//            returned instruction in a buffer while ID is stalled.
//            Optional macro IF_FETCH_PERF_CNT_EN adds stall/bubble counters.
// Revision : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic               IF_ID_Write,
    input  logic               Flush,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] IF_ID_Instr,
    output logic [ADDR_W-1:0]  IF_ID_PC4,
    output logic               IF_ID_Valid,
    output logic               fetch_busy
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_bubble_cnt
`endif
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    state_t               r_state;
    state_t               w_nextState;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_nextPc;
    logic [ADDR_W-1:0]    w_pcPlus4;
    logic [INSTR_W-1:0]   r_buf;
    logic [INSTR_W-1:0]   w_nextBuf;
    logic [INSTR_W-1:0]   r_ifIdInstr;
    logic [INSTR_W-1:0]   w_nextInstr;
    logic [ADDR_W-1:0]    r_ifIdPc4;
    logic [ADDR_W-1:0]    w_nextPc4;
    logic                 r_ifIdValid;
    logic                 w_nextValid;
    logic                 w_accept;

    assign w_accept  = PCWrite & IF_ID_Write;
    assign w_pcPlus4 = r_pc + c_PC_STEP;

    assign imem_req    = (r_state == S_FETCH) & ~rst;
    assign imem_addr   = r_pc;
    assign fetch_busy  = imem_req & ~imem_ready;
    assign IF_ID_Instr = r_ifIdInstr;
    assign IF_ID_PC4   = r_ifIdPc4;
    assign IF_ID_Valid = r_ifIdValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_buf       <= '0;
            r_ifIdInstr <= '0;
            r_ifIdPc4   <= '0;
            r_ifIdValid <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_pc        <= w_nextPc;
            r_buf       <= w_nextBuf;
            r_ifIdInstr <= w_nextInstr;
            r_ifIdPc4   <= w_nextPc4;
            r_ifIdValid <= w_nextValid;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextPc    = r_pc;
        w_nextBuf   = r_buf;
        w_nextInstr = r_ifIdInstr;
        w_nextPc4   = r_ifIdPc4;
        w_nextValid = r_ifIdValid;

        // The branch is older than anything fetched, so it beats any stall.
        if (Flush) begin
            w_nextState = S_FETCH;
            w_nextPc    = BranchTarget;
            w_nextBuf   = '0;
            w_nextInstr = '0;
            w_nextPc4   = '0;
            w_nextValid = 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        if (w_accept) begin
                            w_nextInstr = imem_rdata;
                            w_nextPc4   = w_pcPlus4;
                            w_nextValid = 1'b1;
                            w_nextPc    = w_pcPlus4;
                        end else begin
                            w_nextBuf   = imem_rdata;
                            w_nextState = S_HOLD;
                        end
                    end else if (IF_ID_Write) begin
                        w_nextInstr = '0;
                        w_nextPc4   = '0;
                        w_nextValid = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        w_nextInstr = r_buf;
                        w_nextPc4   = w_pcPlus4;
                        w_nextValid = 1'b1;
                        w_nextPc    = w_pcPlus4;
                        w_nextState = S_FETCH;
                    end
                end
                default: w_nextState = S_FETCH;
            endcase
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] r_stallCnt;
    logic [31:0] r_bubbleCnt;
    logic        w_loadBubble;

    assign w_loadBubble = Flush
                        | ((r_state == S_FETCH) & ~imem_ready & IF_ID_Write);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt  <= '0;
            r_bubbleCnt <= '0;
        end else begin
            if (~w_accept & ~Flush & (r_stallCnt != 32'hFFFF_FFFF))
                r_stallCnt <= r_stallCnt + 32'd1;
            if (w_loadBubble & (r_bubbleCnt != 32'hFFFF_FFFF))
                r_bubbleCnt <= r_bubbleCnt + 32'd1;
        end
    end

    assign perf_stall_cnt  = r_stallCnt;
    assign perf_bubble_cnt = r_bubbleCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Self-checking bench for if_fetch_stage: directed scenarios with
//            literal expectations, then randomized traffic against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b1;
    logic        IF_ID_Write = 1'b1;
    logic        Flush = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b1;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic        fetch_busy;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    int nChecks = 0;
    int nFails  = 0;
    bit armed   = 1'b0;

    // Behavioural model: PC, at most one parked instruction, IF/ID contents.
    logic [31:0] mPc;
    logic [31:0] mHeld[$];
    logic [31:0] mInstr, mPc4;
    logic        mValid;
    logic [31:0] mStall, mBubble;

    always #5 clk = ~clk;

    // Memory content is a fixed function of address; junk when not ready.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA000_0000;
    endfunction
    assign imem_rdata = imem_ready ? memWord(imem_addr) : 32'hDEAD_BEEF;

    if_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .Flush(Flush), .BranchTarget(BranchTarget),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
        .IF_ID_Valid(IF_ID_Valid), .fetch_busy(fetch_busy)
`ifdef IF_FETCH_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic modelStep();
        logic acc;
        logic bubble;
        acc    = PCWrite & IF_ID_Write;
        bubble = 1'b0;
        if (rst) begin
            mPc = 32'h0; mHeld.delete();
            mInstr = '0; mPc4 = '0; mValid = 1'b0;
            mStall = '0; mBubble = '0;
        end else begin
            if (!acc && !Flush && mStall != 32'hFFFF_FFFF) mStall++;
            if (Flush) begin
                mPc = BranchTarget; mHeld.delete();
                mInstr = '0; mPc4 = '0; mValid = 1'b0;
                bubble = 1'b1;
            end else if (mHeld.size() != 0) begin
                if (acc) begin
                    mInstr = mHeld.pop_front(); mPc4 = mPc + 32'd4; mValid = 1'b1;
                    mPc = mPc + 32'd4;
                end
            end else if (imem_ready) begin
                if (acc) begin
                    mInstr = memWord(mPc); mPc4 = mPc + 32'd4; mValid = 1'b1;
                    mPc = mPc + 32'd4;
                end else begin
                    mHeld.push_back(memWord(mPc));
                end
            end else if (IF_ID_Write) begin
                mInstr = '0; mPc4 = '0; mValid = 1'b0;
                bubble = 1'b1;
            end
            if (bubble && mBubble != 32'hFFFF_FFFF) mBubble++;
        end
    endtask

    task automatic cyc(input logic r, input logic pw, input logic iw, input logic fl,
                       input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        rst = r; PCWrite = pw; IF_ID_Write = iw; Flush = fl;
        BranchTarget = tgt; imem_ready = rdy;
        @(posedge clk);
        modelStep();
        #3;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        #2;
        if (armed) begin
            chk("imem_req",  {31'b0, imem_req},   {31'b0, !rst && mHeld.size() == 0});
            chk("imem_addr", imem_addr,           mPc);
            chk("fetch_busy", {31'b0, fetch_busy},
                {31'b0, !rst && mHeld.size() == 0 && !imem_ready});
            chk("IF_ID_Instr", IF_ID_Instr,       mInstr);
            chk("IF_ID_PC4",   IF_ID_PC4,         mPc4);
            chk("IF_ID_Valid", {31'b0, IF_ID_Valid}, {31'b0, mValid});
`ifdef IF_FETCH_PERF_CNT_EN
            chk("perf_stall",  perf_stall_cnt,    mStall);
            chk("perf_bubble", perf_bubble_cnt,   mBubble);
`endif
        end
    end

    initial begin
        logic [31:0] tgt;
        int r;
        cyc(1, 1, 1, 0, 0, 1);
        armed = 1'b1;
        cyc(1, 1, 1, 0, 0, 1);
        chk("reset_valid", {31'b0, IF_ID_Valid}, 32'd0);
        chk("reset_pc4", IF_ID_PC4, 32'd0);

        // Zero-wait stream
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 1, 0, 0, 1);
            chk("stream_pc4", IF_ID_PC4, 32'(4 * i));
            chk("stream_valid", {31'b0, IF_ID_Valid}, 32'd1);
        end
        chk("stream_instr", IF_ID_Instr, 32'hA000_0008);
        cyc(0, 1, 1, 0, 0, 1);

        // Load-use stall while fetching 0x10
        cyc(0, 0, 0, 0, 0, 1);
        chk("stall_hold_instr", IF_ID_Instr, 32'hA000_000C);
        chk("stall_hold_pc4", IF_ID_PC4, 32'h10);
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        cyc(0, 1, 1, 0, 0, 1);
        chk("unstall_instr", IF_ID_Instr, 32'hA000_0010);
        chk("unstall_pc4", IF_ID_PC4, 32'h14);
        repeat (3) cyc(0, 1, 1, 0, 0, 1);

        // Three wait states at 0x20
        repeat (3) begin
            cyc(0, 1, 1, 0, 0, 0);
            chk("wait_valid", {31'b0, IF_ID_Valid}, 32'd0);
            chk("wait_instr", IF_ID_Instr, 32'd0);
            chk("wait_addr", imem_addr, 32'h20);
        end
        cyc(0, 1, 1, 0, 0, 1);
        chk("after_wait_instr", IF_ID_Instr, 32'hA000_0020);
        chk("after_wait_pc4", IF_ID_PC4, 32'h24);

        // Flush beats a simultaneous stall
        cyc(0, 0, 0, 1, 32'h100, 1);
        chk("flush_valid", {31'b0, IF_ID_Valid}, 32'd0);
        chk("flush_addr", imem_addr, 32'h100);

        // Flush while HOLD
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 1, 32'h200, 1);
        chk("holdflush_addr", imem_addr, 32'h200);
        chk("holdflush_req", {31'b0, imem_req}, 32'd1);
        cyc(0, 1, 1, 0, 0, 1);
        chk("holdflush_instr", IF_ID_Instr, 32'hA000_0200);
        chk("holdflush_pc4", IF_ID_PC4, 32'h204);

        // PC wrap-around
        cyc(0, 1, 1, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 1, 1, 0, 0, 1);
        chk("wrap_pc4", IF_ID_PC4, 32'h0);
        chk("wrap_instr", IF_ID_Instr, 32'h5FFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset mid-wait
        cyc(0, 1, 1, 1, 32'h80, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        chk("rstwait_addr", imem_addr, 32'h0);
        chk("rstwait_valid", {31'b0, IF_ID_Valid}, 32'd0);

`ifdef IF_FETCH_PERF_CNT_EN
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 1);
        repeat (3) cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 32'h40, 1);
        chk("perf_stall_lit", perf_stall_cnt, 32'd2);
        chk("perf_bubble_lit", perf_bubble_cnt, 32'd4);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic pw, iw, fl, rd, rs;
            r  = $urandom_range(0, 9);
            pw = (r < 7) || (r == 8);
            iw = (r < 7) || (r == 9);
            fl = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 9) < 7);
            rs = ($urandom_range(0, 199) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
            cyc(rs, pw, iw, fl, tgt, rd);
        end

        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
